// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 asynchronous serial receiver with mid-bit sampling.
// Received bytes are offered on a valid/ready holding register. Framing
// errors and overruns are reported as one-cycle pulses and mirrored as
// sticky bits on the LED bank.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, plus a one-cycle perr output.
module uart_rx_byte #(
  parameter int CDIV = 434,
  parameter int CW   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       ferr,
  output logic       ovr,
`ifdef UART_RX_PARITY_EN
  output logic       perr,
`endif
  output logic [2:0] led
);

  // Half a bit period lands the start sample mid-bit; full periods after that.
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_rs_prev;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_next;
  logic [7:0]      r_shreg;
  logic            w_shift;

  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovr;
  logic            r_ferr_sticky;
  logic            r_ovr_sticky;

  logic            w_rs;
  logic            w_sample;
  logic            w_fall;
  logic            w_done;
  logic            w_ferr_set;
  logic            w_drop;

`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_perr;
  logic            w_par_check;
  logic            w_par_bad;
`endif

  assign w_rs     = r_sync2;
  assign w_sample = (r_cnt == '0);
  assign w_fall   = r_rs_prev & ~w_rs;

`ifdef UART_RX_PARITY_EN
  // Even parity: the XOR of 8 data bits plus the parity bit must be zero.
  assign w_par_bad = ^{r_shreg, w_rs};
`endif

  // Two-flop synchronizer on rxd (idle-high preset) plus edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rs_prev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_rs_prev <= r_sync2;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, bit-period counter reload and sample-point decisions.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt - CW'(1);
    w_bit_next   = r_bit;
    w_shift      = 1'b0;
    w_done       = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_check  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_cnt_next   = HALF_RELOAD;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (w_rs) begin
            // Line is high again at mid start bit: treat as a glitch.
            w_state_next = S_IDLE;
          end else begin
            w_cnt_next   = FULL_RELOAD;
            w_bit_next   = 3'd0;
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift    = 1'b1;
          w_cnt_next = FULL_RELOAD;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          w_par_check  = 1'b1;
          w_cnt_next   = FULL_RELOAD;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_sample) begin
          if (w_rs) begin
            // Back to IDLE at mid stop bit so a following start edge is caught.
`ifdef UART_RX_PARITY_EN
            w_done = ~r_par_bad;
`else
            w_done = 1'b1;
`endif
            w_state_next = S_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must go high before another frame can start.
        if (w_rs) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      r_cnt <= w_cnt_next;
      r_bit <= w_bit_next;
      if (w_shift) begin
        r_shreg <= {w_rs, r_shreg[7:1]};
      end
    end
  end

  // A completed byte is dropped when the holding register is full and not being popped.
  assign w_drop = w_done & r_valid & ~ready;

  // Holding register, error pulses and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data        <= 8'h00;
      r_valid       <= 1'b0;
      r_ferr        <= 1'b0;
      r_ovr         <= 1'b0;
      r_ferr_sticky <= 1'b0;
      r_ovr_sticky  <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set;
      r_ovr  <= w_drop;
      if (w_done && !w_drop) begin
        // Covers both an empty register and a simultaneous pop and load.
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (w_ferr_set) begin
        r_ferr_sticky <= 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (w_par_check && w_par_bad) begin
        r_ferr_sticky <= 1'b1;
      end
`endif
      if (w_drop) begin
        r_ovr_sticky <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict held until the stop bit, plus its one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= w_par_check & w_par_bad;
      if (w_par_check) begin
        r_par_bad <= w_par_bad;
      end
    end
  end

  assign perr = r_perr;
`endif

  assign data  = r_data;
  assign valid = r_valid;
  assign ferr  = r_ferr;
  assign ovr   = r_ovr;
  assign led   = {r_ovr_sticky, r_ferr_sticky, r_valid};

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and randomized checks of uart_rx_byte at CDIV=8.
// A passive monitor logs handshakes and pulse counts; each test task compares
// them against expectations built from the frames it sent.
module tb_uart_rx_byte;

  localparam int CDIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic [2:0] led;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  uart_rx_byte #(.CDIV(CDIV), .CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .ferr  (ferr),
    .ovr   (ovr),
`ifdef UART_RX_PARITY_EN
    .perr  (perr),
`endif
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state: cycle counter, accepted bytes, pulse counts.
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         ferr_n = 0;
  int         ovr_n = 0;
  int         both_n = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid === 1'b1 && ready === 1'b1) got_q.push_back(data);
      if (ferr === 1'b1) ferr_n++;
      if (ovr === 1'b1) ovr_n++;
      if (ferr === 1'b1 && ovr === 1'b1) both_n++;
      if (valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    end
    prev_valid = valid;
  end

  // Drive one frame: start bit, 8 data bits LSB first, stop bit. Call just after a posedge.
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CDIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int base;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rxd = ~rxd;
    end
    @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    n_checks++; if (led !== 3'b000) begin n_fail++; $display("FAIL reset_led: got %b expected 000", led); end
    @(posedge clk);
    #1;
    rxd = 1'b1;
    rst = 1'b0;
    base = got_q.size();
    idle_cycles(50);
    @(negedge clk);
    n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL reset_idle_bytes: got %0d expected 0", got_q.size() - base); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b expected 0", valid); end
    n_checks++; if (ferr_n != 0 || ovr_n != 0) begin n_fail++; $display("FAIL reset_idle_pulses: got ferr=%0d ovr=%0d expected 0/0", ferr_n, ovr_n); end
    $display("reset: done, idle 50 cycles");
  endtask

  task automatic test_single;
    int base, start_cyc;
    base = got_q.size();
    ready = 1'b0;
    rise_cyc = -1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    rxd = 1'b1;
    idle_cycles(4);
    @(negedge clk);
    // rxd edge is seen at t = drive + 2 after synchronization; valid rises at t+77.
    n_checks++; if (rise_cyc - start_cyc != 79) begin n_fail++; $display("FAIL single_latency: got %0d expected 79", rise_cyc - start_cyc); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", valid); end
    n_checks++; if (led !== 3'b001) begin n_fail++; $display("FAIL single_led: got %b expected 001", led); end
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", valid); end
    n_checks++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_q.size() - base); end
    else begin
      n_checks++; if (got_q[base] !== 8'hA5) begin n_fail++; $display("FAIL single_popped: got %h expected a5", got_q[base]); end
    end
    $display("single: sent a5 latency %0d", rise_cyc - start_cyc);
  endtask

  task automatic test_back_to_back;
    int base, f0, o0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    base = got_q.size(); f0 = ferr_n; o0 = ovr_n;
    ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    rxd = 1'b1;
    idle_cycles(20);
    @(negedge clk);
    n_checks++; if (got_q.size() != base + 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got_q.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (got_q[base + i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[base + i], exp_b[i]); end
      end
    end
    n_checks++; if (ferr_n != f0 || ovr_n != o0) begin n_fail++; $display("FAIL b2b_pulses: got ferr=%0d ovr=%0d expected 0/0", ferr_n - f0, ovr_n - o0); end
    $display("b2b: sent 41 42 43, received %0d", got_q.size() - base);
  endtask

  task automatic test_overrun;
    int base, o0;
    base = got_q.size(); o0 = ovr_n;
    ready = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rxd = 1'b1;
    idle_cycles(5);
    @(negedge clk);
    n_checks++; if (ovr_n - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_n - o0); end
    n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %h expected 11", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", valid); end
    n_checks++; if (led !== 3'b101) begin n_fail++; $display("FAIL ovr_led: got %b expected 101", led); end
    @(posedge clk);
    #1;
    ready = 1'b1;
    idle_cycles(20);
    @(negedge clk);
    n_checks++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL ovr_drain_count: got %0d expected 1", got_q.size() - base); end
    else begin
      n_checks++; if (got_q[base] !== 8'h11) begin n_fail++; $display("FAIL ovr_drain_byte: got %h expected 11", got_q[base]); end
    end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b expected 0", valid); end
    $display("overrun: sent 11 22 with ready=0, ovr pulses %0d", ovr_n - o0);
  endtask

  task automatic test_framing;
    int base, f0;
    base = got_q.size(); f0 = ferr_n;
    ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b0);
    rxd = 1'b0;
    idle_cycles(3 * CDIV);
    @(negedge clk);
    n_checks++; if (ferr_n - f0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_n - f0); end
    n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL ferr_bytes: got %0d expected 0", got_q.size() - base); end
    n_checks++; if (led[1] !== 1'b1) begin n_fail++; $display("FAIL ferr_led1: got %b expected 1", led[1]); end
    @(posedge clk);
    #1;
    rxd = 1'b1;
    idle_cycles(10);
    send_frame(8'h77, 1'b1);
    rxd = 1'b1;
    idle_cycles(20);
    @(negedge clk);
    n_checks++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", got_q.size() - base); end
    else begin
      n_checks++; if (got_q[base] !== 8'h77) begin n_fail++; $display("FAIL ferr_recover_byte: got %h expected 77", got_q[base]); end
    end
    n_checks++; if (ferr_n - f0 != 1) begin n_fail++; $display("FAIL ferr_break_hold: got %0d expected 1", ferr_n - f0); end
    $display("framing: 5a with low stop, then 77 after line release");
  endtask

  task automatic test_glitch;
    int base, f0;
    base = got_q.size(); f0 = ferr_n;
    @(posedge clk);
    #1;
    rxd = 1'b0;
    idle_cycles(2);
    rxd = 1'b1;
    idle_cycles(100);
    @(negedge clk);
    n_checks++; if (got_q.size() != base || valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got bytes=%0d valid=%b expected 0/0", got_q.size() - base, valid); end
    n_checks++; if (ferr_n != f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_n - f0); end
    $display("glitch: 2-cycle low pulse ignored");
  endtask

  task automatic test_reset_mid;
    int base, f0;
    base = got_q.size(); f0 = ferr_n;
    ready = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle_cycles(8 * 5 + 4);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
      end
    join
    rxd = 1'b1;
    idle_cycles(20);
    @(negedge clk);
    n_checks++; if (got_q.size() != base) begin n_fail++; $display("FAIL rstmid_bytes: got %0d expected 0", got_q.size() - base); end
    n_checks++; if (ferr_n != f0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d expected 0", ferr_n - f0); end
    n_checks++; if (led !== 3'b000) begin n_fail++; $display("FAIL rstmid_led: got %b expected 000", led); end
    send_frame(8'h3C, 1'b1);
    rxd = 1'b1;
    idle_cycles(20);
    @(negedge clk);
    n_checks++; if (got_q.size() != base + 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected 1", got_q.size() - base); end
    else begin
      n_checks++; if (got_q[base] !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_byte: got %h expected 3c", got_q[base]); end
    end
    $display("reset_mid: ff aborted, 3c received");
  endtask

  task automatic test_random;
    int base, f0, o0, n_bad;
    logic [7:0] exp_q[$];
    logic       rnd_on;
    base = got_q.size(); f0 = ferr_n; o0 = ovr_n; n_bad = 0;
    rnd_on = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          logic [7:0] b;
          logic       bad;
          int         gap;
          b   = 8'($urandom);
          bad = ($urandom_range(0, 4) == 0);
          gap = bad ? CDIV + int'($urandom_range(0, 10)) : int'($urandom_range(0, 10));
          send_frame(b, ~bad);
          rxd = 1'b1;
          // Model: only frames with a high stop bit deliver a byte, in order.
          if (bad) n_bad++;
          else exp_q.push_back(b);
          $display("random: frame %0d byte %h stop=%b gap %0d", k, b, ~bad, gap);
          idle_cycles(gap);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ready = 1'b1;
    idle_cycles(100);
    @(negedge clk);
    n_checks++; if (got_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (got_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]); end
      end
    end
    n_checks++; if (ferr_n - f0 != n_bad) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_n - f0, n_bad); end
    n_checks++; if (ovr_n != o0) begin n_fail++; $display("FAIL rand_ovr: got %0d expected 0", ovr_n - o0); end
    n_checks++; if (both_n != 0) begin n_fail++; $display("FAIL ferr_ovr_overlap: got %0d expected 0", both_n); end
    n_checks++; if (led[2] !== 1'b0) begin n_fail++; $display("FAIL rand_led2: got %b expected 0", led[2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
